// File: rtl/vpe_pkg.sv
// vpe_pkg: shared op/state types, default sizes and lane-slice helper for the vector PE stream.
package vpe_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_MAX, OP_MIN, OP_DOT, OP_PASS
  } vpe_op_t;
  typedef enum logic {IDLE, IN_PKT} vpe_state_t;
  localparam int DEF_DWIDTH = 32;
  localparam int DEF_SIMD_DEGREE = 16;
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/vpe_lane.sv
// vpe_lane: one lane's op mux, dot-product accumulator and fixed-latency result pipeline.
module vpe_lane import vpe_pkg::*; #(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LATENCY = 4
) (
  input logic clk,
  input logic rst,
  input logic fire_i,
  input logic first_i,
  input logic en_i,
  input vpe_op_t op_i,
  input logic [DWIDTH-1:0] a_i,
  input logic [DWIDTH-1:0] b_i,
  input logic [DWIDTH-1:0] c_i,
  output logic [DWIDTH-1:0] y_o
);
  logic [DWIDTH-1:0] prod, acc_base, res, acc_q;
  logic [DWIDTH-1:0] pipe_q [LATENCY];
  always_comb begin
    prod = a_i * b_i;
    acc_base = first_i ? '0 : acc_q;
    res = op_i == OP_ADD ? a_i + b_i :
          op_i == OP_SUB ? a_i - b_i :
          op_i == OP_MUL ? prod :
          op_i == OP_MAC ? prod + c_i :
          op_i == OP_MAX ? ($signed(a_i) > $signed(b_i) ? a_i : b_i) :
          op_i == OP_MIN ? ($signed(a_i) < $signed(b_i) ? a_i : b_i) :
          op_i == OP_DOT ? acc_base + prod : a_i;
    res = en_i ? res : '0;
  end
  // data stages run freely; the top's valid pipeline decides what reaches the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      if (fire_i) acc_q <= en_i ? acc_base + prod : '0;
      pipe_q[0] <= res;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign y_o = pipe_q[LATENCY-1];
endmodule

// File: rtl/vectorized_pe_stream.sv
// vectorized_pe_stream: SIMD PE array with joined A/B streams, credit-guarded FWFT output FIFO.
// Optional per-packet lane masking is enabled by defining VPE_LANE_MASK_EN.
module vectorized_pe_stream import vpe_pkg::*; #(
  parameter int SIMD_DEGREE = DEF_SIMD_DEGREE,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LATENCY = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
`ifdef VPE_LANE_MASK_EN
  input logic [SIMD_DEGREE-1:0] lane_mask,
`endif
  input logic [2:0] op,
  input logic [SIMD_DEGREE*DWIDTH-1:0] s_a_tdata,
  input logic s_a_tvalid,
  input logic s_a_tlast,
  output logic s_a_tready,
  input logic [SIMD_DEGREE*DWIDTH-1:0] s_b_tdata,
  input logic s_b_tvalid,
  input logic s_b_tlast,
  output logic s_b_tready,
  input logic [SIMD_DEGREE*DWIDTH-1:0] s_c_tdata,
  output logic [SIMD_DEGREE*DWIDTH-1:0] m_tdata,
  output logic m_tvalid,
  output logic m_tlast,
  input logic m_tready,
  output logic err_tlast,
  output logic busy
);
  localparam int W = SIMD_DEGREE * DWIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  vpe_state_t state_q;
  vpe_op_t op_q, eff_op;
  logic [CW-1:0] cred_q, fcnt_q;
  logic [AW-1:0] wp_q, rp_q;
  logic [LATENCY-1:0] vld_q, lst_q;
  logic [W-1:0] fd_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fl_q;
  logic [W-1:0] y;
  logic [SIMD_DEGREE-1:0] eff_mask;
  logic credit_ok, fire, pop, wr, beat_last, first, err_q;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign credit_ok = cred_q < CW'(FIFO_DEPTH);
  assign s_a_tready = s_b_tvalid & credit_ok;
  assign s_b_tready = s_a_tvalid & credit_ok;
  assign fire = s_a_tvalid & s_b_tvalid & credit_ok;
  assign beat_last = s_a_tlast | s_b_tlast;
  assign first = state_q == IDLE;
  assign eff_op = first ? vpe_op_t'(op) : op_q;
  assign m_tvalid = fcnt_q != '0;
  assign pop = m_tvalid & m_tready;
  assign wr = vld_q[LATENCY-1];
  assign m_tdata = m_tvalid ? fd_q[rp_q] : '0;
  assign m_tlast = m_tvalid & fl_q[rp_q];
  assign err_tlast = err_q;
  assign busy = state_q == IN_PKT || cred_q != '0;
`ifdef VPE_LANE_MASK_EN
  logic [SIMD_DEGREE-1:0] mask_q;
  assign eff_mask = first ? lane_mask : mask_q;
  always_ff @(posedge clk) begin
    if (rst) mask_q <= '0;
    else if (fire && first) mask_q <= lane_mask;
  end
`else
  assign eff_mask = '1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= OP_ADD;
      err_q <= 1'b0;
    end else if (fire) begin
      if (first) op_q <= eff_op;
      state_q <= beat_last ? IDLE : IN_PKT;
      if (s_a_tlast != s_b_tlast) err_q <= 1'b1;
    end
  end
  // credits cover pipeline plus FIFO, so a write can never find the FIFO full
  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q <= '0;
      fcnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
      fl_q <= '0;
    end else begin
      cred_q <= fire && !pop ? cred_q + 1'b1 : !fire && pop ? cred_q - 1'b1 : cred_q;
      fcnt_q <= wr && !pop ? fcnt_q + 1'b1 : !wr && pop ? fcnt_q - 1'b1 : fcnt_q;
      vld_q[0] <= fire;
      lst_q[0] <= beat_last;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      if (wr) begin
        fd_q[wp_q] <= y;
        fl_q[wp_q] <= lst_q[LATENCY-1];
        wp_q <= nxt(wp_q);
      end
      if (pop) rp_q <= nxt(rp_q);
    end
  end
  for (genvar g = 0; g < SIMD_DEGREE; g++) begin : g_lane
    vpe_lane #(.DWIDTH(DWIDTH), .LATENCY(LATENCY)) u_lane (
      .clk(clk),
      .rst(rst),
      .fire_i(fire),
      .first_i(first),
      .en_i(eff_mask[g]),
      .op_i(eff_op),
      .a_i(s_a_tdata[lane_lo(g, DWIDTH) +: DWIDTH]),
      .b_i(s_b_tdata[lane_lo(g, DWIDTH) +: DWIDTH]),
      .c_i(s_c_tdata[lane_lo(g, DWIDTH) +: DWIDTH]),
      .y_o(y[lane_lo(g, DWIDTH) +: DWIDTH])
    );
  end
endmodule

// File: tb/tb_vectorized_pe_stream.sv
// tb_vectorized_pe_stream: directed self-checking bench for vectorized_pe_stream (4 lanes x 32 bits).
module tb_vectorized_pe_stream;
  localparam int W = 128;
  logic clk = 0, rst = 1, m_tready = 1;
  logic [2:0] op = 0;
  logic [W-1:0] s_a_tdata = 0, s_b_tdata = 0, s_c_tdata = 0, m_tdata;
  logic s_a_tvalid = 0, s_a_tlast = 0, s_b_tvalid = 0, s_b_tlast = 0;
  logic s_a_tready, s_b_tready, m_tvalid, m_tlast, err_tlast, busy;
  int checks = 0, errors = 0;
  vectorized_pe_stream #(.SIMD_DEGREE(4), .DWIDTH(32), .LATENCY(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .op(op),
    .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tlast(s_a_tlast), .s_a_tready(s_a_tready),
    .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tlast(s_b_tlast), .s_b_tready(s_b_tready),
    .s_c_tdata(s_c_tdata), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .err_tlast(err_tlast), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [W-1:0] rep(input logic [31:0] v);
    return {4{v}};
  endfunction
  task automatic send(input logic [2:0] o, input logic [W-1:0] va, vb, vc, input logic la, lb);
    int n = 0;
    op = o; s_a_tdata = va; s_b_tdata = vb; s_c_tdata = vc;
    s_a_tlast = la; s_b_tlast = lb; s_a_tvalid = 1; s_b_tvalid = 1;
    #1;
    while (!s_a_tready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL send_timeout ready=%0b want 1", s_a_tready); end
    @(posedge clk); #1;
    s_a_tvalid = 0; s_b_tvalid = 0; s_a_tlast = 0; s_b_tlast = 0;
  endtask
  task automatic recv(output logic [W-1:0] d, output logic l);
    int n = 0;
    while (!m_tvalid && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL recv_timeout m_tvalid=%0b want 1", m_tvalid); end
    d = m_tdata; l = m_tlast;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checks++; if (m_tvalid !== 0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    checks++; if (m_tlast !== 0) begin errors++; $display("FAIL reset_tlast got %0b want 0", m_tlast); end
    checks++; if (err_tlast !== 0 || busy !== 0) begin errors++; $display("FAIL reset_err_busy got %0b%0b want 00", err_tlast, busy); end
    s_b_tvalid = 1; #1;
    checks++; if (s_a_tready !== 1) begin errors++; $display("FAIL reset_a_ready got %0b want 1", s_a_tready); end
    s_b_tvalid = 0;
  endtask
  task automatic test_add();
    m_tready = 1;
    send(3'b000, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10}, '0, 1, 1);
    checks++; if (m_tvalid !== 0) begin errors++; $display("FAIL add_early_k0 got %0b want 0", m_tvalid); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (m_tvalid !== 0) begin errors++; $display("FAIL add_early_k3 got %0b want 0", m_tvalid); end
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 1) begin errors++; $display("FAIL add_valid_k4 got %0b want 1", m_tvalid); end
    checks++; if (m_tdata !== {32'd44, 32'd33, 32'd22, 32'd11} || m_tlast !== 1) begin
      errors++; $display("FAIL add_data got %h/%0b want 0000002c00000021000000160000000b/1", m_tdata, m_tlast); end
    @(posedge clk); #1;
    checks++; if (m_tvalid !== 0) begin errors++; $display("FAIL add_popped got %0b want 0", m_tvalid); end
  endtask
  task automatic test_dot();
    logic [W-1:0] d; logic l;
    m_tready = 0;
    for (int i = 0; i < 6; i++) send(3'b110, rep(2), rep(3), '0, i % 3 == 2, i % 3 == 2);
    m_tready = 1;
    for (int i = 0; i < 6; i++) begin
      recv(d, l);
      checks++; if (d !== rep(6 * (i % 3 + 1)) || l !== (i % 3 == 2)) begin
        errors++; $display("FAIL dot_beat%0d got %h/%0b want %h/%0b", i, d, l, rep(6 * (i % 3 + 1)), i % 3 == 2); end
    end
  endtask
  task automatic test_backpressure();
    int acc = 0;
    logic f;
    m_tready = 0;
    op = 3'b000; s_a_tdata = rep(0); s_b_tdata = rep(100); s_a_tvalid = 1; s_b_tvalid = 1;
    repeat (30) begin
      #1 f = s_a_tready;
      @(posedge clk); #1;
      if (f) begin acc++; s_a_tdata = rep(acc); end
    end
    checks++; if (acc != 8) begin errors++; $display("FAIL bp_accepted got %0d want 8", acc); end
    checks++; if (s_a_tready !== 0 || s_b_tready !== 0) begin errors++; $display("FAIL bp_ready got %0b%0b want 00", s_a_tready, s_b_tready); end
    s_a_tvalid = 0; s_b_tvalid = 0;
    m_tready = 1;
    fork
      begin
        for (int i = 8; i < 20; i++) send(3'b000, rep(i), rep(100), '0, i == 19, i == 19);
      end
      begin
        logic [W-1:0] d; logic l;
        for (int j = 0; j < 20; j++) begin
          recv(d, l);
          checks++; if (d !== rep(j + 100) || l !== (j == 19)) begin
            errors++; $display("FAIL bp_beat%0d got %h/%0b want %h/%0b", j, d, l, rep(j + 100), j == 19); end
        end
      end
    join
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 0 || m_tvalid !== 0) begin errors++; $display("FAIL bp_drained busy/valid got %0b%0b want 00", busy, m_tvalid); end
  endtask
  task automatic test_op_latch();
    logic [W-1:0] d; logic l;
    m_tready = 0;
    send(3'b000, rep(5), rep(3), '0, 0, 0);
    send(3'b001, rep(5), rep(3), '0, 0, 0);
    send(3'b001, rep(5), rep(3), '0, 1, 1);
    send(3'b001, rep(5), rep(3), '0, 1, 1);
    m_tready = 1;
    for (int i = 0; i < 3; i++) begin
      recv(d, l);
      checks++; if (d !== rep(8) || l !== (i == 2)) begin errors++; $display("FAIL latch_beat%0d got %h/%0b want %h/%0b", i, d, l, rep(8), i == 2); end
    end
    recv(d, l);
    checks++; if (d !== rep(2) || l !== 1) begin errors++; $display("FAIL latch_next got %h/%0b want %h/1", d, l, rep(2)); end
  endtask
  task automatic test_arith();
    logic [W-1:0] d; logic l;
    m_tready = 1;
    send(3'b100, rep(32'hFFFFFFFF), rep(1), '0, 1, 1); recv(d, l);
    checks++; if (d !== rep(1)) begin errors++; $display("FAIL max got %h want %h", d, rep(1)); end
    send(3'b101, rep(32'hFFFFFFFF), rep(1), '0, 1, 1); recv(d, l);
    checks++; if (d !== rep(32'hFFFFFFFF)) begin errors++; $display("FAIL min got %h want %h", d, rep(32'hFFFFFFFF)); end
    send(3'b010, rep(32'h80000000), rep(2), '0, 1, 1); recv(d, l);
    checks++; if (d !== rep(0)) begin errors++; $display("FAIL mul got %h want %h", d, rep(0)); end
    send(3'b011, rep(3), rep(4), rep(32'hFFFFFFFF), 1, 1); recv(d, l);
    checks++; if (d !== rep(11)) begin errors++; $display("FAIL mac got %h want %h", d, rep(11)); end
    send(3'b111, rep(32'h1234), rep(9), '0, 1, 1); recv(d, l);
    checks++; if (d !== rep(32'h1234)) begin errors++; $display("FAIL pass got %h want %h", d, rep(32'h1234)); end
    checks++; if (err_tlast !== 0) begin errors++; $display("FAIL err_clean got %0b want 0", err_tlast); end
  endtask
  task automatic test_tlast_err();
    logic [W-1:0] d; logic l;
    m_tready = 1;
    send(3'b111, rep(7), rep(9), '0, 1, 0); recv(d, l);
    checks++; if (d !== rep(7) || l !== 1) begin errors++; $display("FAIL tlast_mix got %h/%0b want %h/1", d, l, rep(7)); end
    checks++; if (err_tlast !== 1) begin errors++; $display("FAIL err_set got %0b want 1", err_tlast); end
    send(3'b000, rep(1), rep(1), '0, 1, 1); recv(d, l);
    checks++; if (d !== rep(2) || err_tlast !== 1) begin errors++; $display("FAIL err_sticky got %h/%0b want %h/1", d, err_tlast, rep(2)); end
  endtask
  task automatic test_rst_inflight();
    logic seen = 0;
    m_tready = 1;
    send(3'b000, rep(1), rep(1), '0, 0, 0);
    send(3'b000, rep(1), rep(1), '0, 0, 0);
    send(3'b000, rep(1), rep(1), '0, 1, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    checks++; if (m_tvalid !== 0 || busy !== 0) begin errors++; $display("FAIL rst_valid_busy got %0b%0b want 00", m_tvalid, busy); end
    checks++; if (err_tlast !== 0) begin errors++; $display("FAIL rst_err got %0b want 0", err_tlast); end
    repeat (10) begin @(posedge clk); #1; if (m_tvalid) seen = 1; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_stale got %0b want 0", seen); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_dot();
    test_backpressure();
    test_op_latch();
    test_arith();
    test_tlast_err();
    test_rst_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vectorized_pe_stream.md
Name: vectorized_pe_stream

Overview:
Parametrised SIMD processing-element array with full AXI-stream handshakes on two joined operand streams and one result stream.
- Each lane is a fixed-latency integer datapath; the op is latched once per packet.
- An output FIFO, guarded by credit accounting, absorbs downstream backpressure without dropping in-flight results.
- Sits between the CGRA operand routers and the result network, replacing the valid-only vector PE stage.

Parameters:
SIMD_DEGREE, 16, number of lanes
DWIDTH, 32, lane width in bits (two's complement)
LATENCY, 4, accept-to-FIFO-write pipeline depth (>=1)
FIFO_DEPTH, 8, output FIFO entries (>= LATENCY)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op  in  3  operation select, sampled at first beat of each packet
s_a_tdata  in  SIMD_DEGREE*DWIDTH  operand A, lane i at bits [(i+1)*DWIDTH-1 : i*DWIDTH]
s_a_tvalid / s_a_tlast  in  1 each  A stream valid / last
s_a_tready  out  1  A ready
s_b_tdata  in  SIMD_DEGREE*DWIDTH  operand B
s_b_tvalid / s_b_tlast  in  1 each  B stream valid / last
s_b_tready  out  1  B ready
s_c_tdata  in  SIMD_DEGREE*DWIDTH  operand C, sideband, sampled on accept
m_tdata  out  SIMD_DEGREE*DWIDTH  result
m_tvalid / m_tlast  out  1 each  result valid / last
m_tready  in  1  downstream ready
err_tlast  out  1  sticky: A/B tlast disagreed on an accepted beat
busy  out  1  state IN_PKT, or credits > 0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; FIFO empty; credits 0; pipeline valids cleared; accumulators 0; state IDLE; err_tlast cleared.
  - Reset mid-operation discards all in-flight and queued beats.
- Join handshake:
  - credit_ok = credits < FIFO_DEPTH.
  - s_a_tready = s_b_tvalid & credit_ok; s_b_tready = s_a_tvalid & credit_ok.
  - Beat accepted (fire) iff s_a_tvalid & s_b_tvalid & credit_ok.
  - Readies never depend combinationally on m_tready.
- Credits = beats in pipeline + FIFO occupancy.
  - +1 on fire, -1 on pop (m_tvalid & m_tready); simultaneous fire and pop leaves it unchanged.
  - Overflow of the FIFO is therefore impossible.
- FSM:
  - IDLE --fire--> IN_PKT, latching op; if that beat carries tlast, stay IDLE.
  - IN_PKT --fire with tlast--> IDLE.
  - op changes while IN_PKT are ignored until the next packet.
- tlast: beat last = s_a_tlast | s_b_tlast. If they differ on a fired beat, set err_tlast (sticky until rst).
- Ops per lane, results modulo 2^DWIDTH:
  - 000 ADD a+b
  - 001 SUB a-b
  - 010 MUL low DWIDTH bits of a*b
  - 011 MAC a*b+c
  - 100 MAX signed
  - 101 MIN signed
  - 110 DOT running sum: out = acc + a*b; acc updated on fire; acc treated as 0 on the packet's first beat
  - 111 PASS a
- Latency: beat fired at edge k is written to the FIFO at edge k+LATENCY.
  - FIFO is first-word-fall-through: with an empty FIFO, m_tvalid=1 in the cycle after edge k+LATENCY.
  - Order is preserved; m_tdata and m_tlast hold stable while m_tvalid & !m_tready.
- Full/empty: FIFO full implies credits = FIFO_DEPTH, so both readies are 0. Empty implies m_tvalid = 0.

Optional Feature:
VPE_LANE_MASK_EN
- Defined: adds input lane_mask [SIMD_DEGREE], latched with op at packet start. Masked lanes output 0 and hold acc at 0; tvalid/tlast behaviour is unchanged.
- Undefined: port absent; all lanes active.

Decomposition:
- Package vpe_pkg holds:
  - the op enum (vpe_op_t)
  - default DWIDTH and SIMD_DEGREE constants
  - the lane-slice index helper function
- Sub-module vpe_lane: one lane's op mux, accumulator and LATENCY-deep register pipeline, generated SIMD_DEGREE times.
- Top module owns: join, FSM, credit counter, shared valid/last pipeline and FIFO.

Test Plan:
All tests use SIMD_DEGREE=4, DWIDTH=32, LATENCY=4, FIFO_DEPTH=8.
- ADD: single tlast beat, a={1,2,3,4}, b={10,20,30,40} -> m_tdata {11,22,33,44}, m_tlast=1, m_tvalid rises the cycle after accept edge+4.
- DOT: 3-beat packet, a=2, b=3 all lanes -> outputs 6, 12, 18 with tlast on the third; second identical packet -> 6, 12, 18 (acc restarts).
- Backpressure: m_tready=0, 20 beats offered -> exactly 8 accepted, then readies 0; m_tready=1 -> all 20 emerge in order, credits return to 0.
- Op latch: op=ADD at beat 1, switched to SUB before beat 2 of a 3-beat packet -> all 3 results are sums; next packet produces differences.
- Arithmetic edges:
  - a=0xFFFFFFFF, b=1: MAX -> 1, MIN -> 0xFFFFFFFF.
  - MUL 0x80000000*2 -> 0.
  - MAC 3*4+0xFFFFFFFF -> 11.
- Faults:
  - s_a_tlast=1 with s_b_tlast=0 -> m_tlast=1 and err_tlast stays 1.
  - rst with 3 beats in flight -> m_tvalid=0 after the reset edge, no stale beat emerges, err_tlast=0.
